enable_sequencer: RTL and testbench
===================================

Name: enable_sequencer

Overview:
- Sits directly downstream of enable_generator_core and consumes its periodic single-cycle enable_out pulse.
- Each accepted trigger pulse expands into a per-channel sequence of single-cycle enables, each delayed by its own programmable number of clock cycles.
- Used to stagger ADC start-of-conversion, PWM update and control-loop start relative to one timebase tick.
- Reports busy state and counts triggers that arrive while a sequence is still running.

Parameters:
- N_OUTPUTS, 4, number of delayed enable channels (1..16).
- DELAY_WIDTH, 16, width of each per-channel delay value and of the internal cycle counter.
- OVERRUN_WIDTH, 16, width of the saturating overrun counter.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable_in  in  1  trigger pulse, normally enable_generator_core.enable_out.
- sequence_enable  in  1  global enable; when low, triggers are ignored and any running sequence is aborted.
- delays  in  N_OUTPUTS*DELAY_WIDTH  per-channel delays; channel i occupies bits [i*DELAY_WIDTH +: DELAY_WIDTH].
- clear_overrun  in  1  synchronous clear of overrun_count.
- enable_out  out  N_OUTPUTS  one-cycle delayed enables, one bit per channel.
- busy  out  1  high while a sequence is running.
- overrun_count  out  OVERRUN_WIDTH  number of triggers lost while busy.

Behaviour:
- Reset: when reset=1 at a rising edge, the next state is IDLE, counter=0, latched delays=0, enable_out=0, busy=0, overrun_count=0.
- FSM states: IDLE and RUN. busy is registered and equals (state==RUN).
- Accepting a trigger: in IDLE, if enable_in=1 and sequence_enable=1 at an edge:
  - snapshot all delays into internal registers;
  - snapshot max_delay = maximum of the N delays;
  - load counter=0 and go to RUN.
- Delay changes: after the snapshot, changes on delays have no effect until the next accepted trigger.
- RUN: counter increments by 1 each cycle.
- Output timing: enable_out[i] is registered and is high for exactly one cycle when counter == latched_delay[i].
  - For a trigger sampled at edge t, enable_out[i] is high in the cycle after edge t+1+delay[i].
  - Delay 0 gives one cycle of latency.
- Equal delays on several channels make those channels pulse in the same cycle.
- Sequence end: the terminal cycle is the one where counter == max_delay. It emits its pulses, then:
  - enable_in=1 and sequence_enable=1 in that cycle: back-to-back restart; re-snapshot, counter=0, stay in RUN, overrun_count unchanged;
  - otherwise: go to IDLE.
- Overrun: enable_in=1 in RUN in any non-terminal cycle is ignored and increments overrun_count.
  - overrun_count saturates at 2^OVERRUN_WIDTH-1.
- clear_overrun=1 sets overrun_count to 0. If clear and increment happen in the same cycle, clear wins and the result is 0.
- Abort: sequence_enable=0 while in RUN aborts at the next edge.
  - Go to IDLE; no further enable_out pulses.
  - Pulses already registered for the current cycle still complete.
  - Counter is cleared.
- Triggers in IDLE with sequence_enable=0 are ignored and are not counted as overruns.
- Counter width: the counter never exceeds max_delay, so no wrap-around is possible. A max_delay of 2^DELAY_WIDTH-1 is legal.
- Reset during RUN: aborts immediately per the reset values above; no pulses after the reset edge.

Test Plan:
- Basic sequence: delays={0,3,7,12}, sequence_enable=1, enable_in pulse at edge t.
  - Required: enable_out[0..3] pulse after edges t+1, t+4, t+8, t+13.
  - Required: busy high from after t+1 to after t+13, back to 0 after t+14.
- Overrun: same delays, second enable_in at t+5 and third at t+13.
  - Required: the t+5 pulse is ignored and overrun_count=1.
  - Required: the t+13 pulse restarts the sequence with no gap; channel 0 pulses after t+14.
- Delay snapshot: delays={2,2,2,2}; change delays to {9,9,9,9} one cycle after the trigger.
  - Required: all four outputs pulse simultaneously after t+3; the new values apply only to the next trigger.
- Abort and gating: sequence_enable drops at t+4 with delays={0,3,7,12}.
  - Required: pulses only on channels 0 and 1; busy=0 after t+5.
  - Required: a later enable_in with sequence_enable=0 produces no output and no overrun.
- Overrun clear and saturation: OVERRUN_WIDTH=2.
  - Required: five overruns give overrun_count=3.
  - Required: clear_overrun asserted together with an overrun event gives 0.
- Reset mid-sequence: assert reset at t+5 of the basic sequence.
  - Required: all outputs 0 from t+6 onward.
  - Required: a trigger after reset deasserts starts a fresh sequence.

Source files
------------

// File: rtl/enable_sequencer.sv
// enable_sequencer: expands one trigger pulse into per-channel single-cycle
// enables, each delayed by its own cycle count latched at trigger time.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for an enabled trigger; no enables are emitted
//   RUN   | counter walks 0..max_delay; channel i fires when counter==delay[i]
module enable_sequencer #(
  parameter int N_OUTPUTS     = 4,
  parameter int DELAY_WIDTH   = 16,
  parameter int OVERRUN_WIDTH = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable_in,
  input  logic                             sequence_enable,
  input  logic [N_OUTPUTS*DELAY_WIDTH-1:0] delays,
  input  logic                             clear_overrun,
  output logic [N_OUTPUTS-1:0]             enable_out,
  output logic                             busy,
  output logic [OVERRUN_WIDTH-1:0]         overrun_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                           state, state_next;
  logic [DELAY_WIDTH-1:0]           counter, counter_next;
  logic [N_OUTPUTS*DELAY_WIDTH-1:0] delay_lat;
  logic [DELAY_WIDTH-1:0]           max_delay;
  logic [DELAY_WIDTH-1:0]           delays_max;
  logic [N_OUTPUTS-1:0]             hit;
  logic                             terminal;
  logic                             snapshot;
  logic                             overrun_evt;

  // Largest of the live delay inputs, captured together with them on a trigger.
  always_comb begin
    delays_max = '0;
    for (int i = 0; i < N_OUTPUTS; i++) begin
      if (delays[i*DELAY_WIDTH +: DELAY_WIDTH] > delays_max)
        delays_max = delays[i*DELAY_WIDTH +: DELAY_WIDTH];
    end
  end

  // Per-channel match of the running counter against the latched delays.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_OUTPUTS; i++)
      hit[i] = (counter == delay_lat[i*DELAY_WIDTH +: DELAY_WIDTH]);
  end

  // Next-state, counter and event decode.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    snapshot     = 1'b0;
    overrun_evt  = 1'b0;
    terminal     = (counter == max_delay);
    case (state)
      ST_IDLE: begin
        if (enable_in && sequence_enable) begin
          snapshot     = 1'b1;
          counter_next = '0;
          state_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        // A trigger landing on the terminal cycle is a restart, never an overrun.
        overrun_evt = enable_in && !terminal;
        if (!sequence_enable) begin
          state_next   = ST_IDLE;
          counter_next = '0;
        end else if (terminal) begin
          counter_next = '0;
          if (enable_in)
            snapshot = 1'b1;
          else
            state_next = ST_IDLE;
        end else begin
          counter_next = counter + 1'b1;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        counter_next = '0;
      end
    endcase
  end

  // State, counter, delay snapshot and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      counter    <= '0;
      delay_lat  <= '0;
      max_delay  <= '0;
      enable_out <= '0;
      busy       <= 1'b0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      if (snapshot) begin
        delay_lat <= delays;
        max_delay <= delays_max;
      end
      // Matches in the abort cycle still fire; nothing fires once IDLE.
      enable_out <= (state == ST_RUN) ? hit : '0;
      busy       <= (state == ST_RUN);
    end
  end

  // Saturating count of triggers lost while a sequence was running; clear wins.
  always_ff @(posedge clock) begin
    if (reset || clear_overrun)
      overrun_count <= '0;
    else if (overrun_evt && (overrun_count != {OVERRUN_WIDTH{1'b1}}))
      overrun_count <= overrun_count + 1'b1;
  end

endmodule

// File: tb/tb_enable_sequencer.sv
// Self-checking bench for enable_sequencer: vector table, directed corner
// sequences and a randomized run against an elapsed-time reference model.
module tb_enable_sequencer;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable_in;
  logic          sequence_enable;
  logic          clear_overrun;
  logic [N*DW-1:0] delays;
  logic [N-1:0]  enable_out, enable_out_s;
  logic          busy, busy_s;
  logic [15:0]   overrun_count;
  logic [1:0]    overrun_s;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  enable_sequencer #(.N_OUTPUTS(N), .DELAY_WIDTH(DW), .OVERRUN_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .enable_in(enable_in),
    .sequence_enable(sequence_enable), .delays(delays),
    .clear_overrun(clear_overrun), .enable_out(enable_out),
    .busy(busy), .overrun_count(overrun_count)
  );

  enable_sequencer #(.N_OUTPUTS(N), .DELAY_WIDTH(DW), .OVERRUN_WIDTH(2)) dut_sat (
    .clock(clock), .reset(reset), .enable_in(enable_in),
    .sequence_enable(sequence_enable), .delays(delays),
    .clear_overrun(clear_overrun), .enable_out(enable_out_s),
    .busy(busy_s), .overrun_count(overrun_s)
  );

  typedef struct {
    logic [N*DW-1:0] dly;
    logic [3:0][7:0] pulse;     // edge offset after the trigger edge per channel
    int              busy_last; // last edge offset after which busy is high
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(input int d0, input int d1, input int d2, input int d3,
                              input int bl);
    vec_t r;
    r.dly       = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
    r.pulse[0]  = 8'(d0 + 1);
    r.pulse[1]  = 8'(d1 + 1);
    r.pulse[2]  = 8'(d2 + 1);
    r.pulse[3]  = 8'(d3 + 1);
    r.busy_last = bl;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic trigger();
    enable_in = 1'b1;
    tick();
    enable_in = 1'b0;
  endtask

  task automatic run_vec(input int v, input string tag);
    logic [N-1:0] expv;
    delays = vecs[v].dly;
    trigger();
    for (int k = 1; k <= vecs[v].busy_last + 2; k++) begin
      tick();
      for (int i = 0; i < N; i++) expv[i] = (k == int'(vecs[v].pulse[i]));
      chk($sformatf("%s%0d_out_k%0d", tag, v, k), 32'(enable_out), 32'(expv));
      chk($sformatf("%s%0d_busy_k%0d", tag, v, k), 32'(busy),
          32'(k <= vecs[v].busy_last));
    end
  endtask

  // Reference model: tracks the edge a sequence started on and derives every
  // output from the number of edges elapsed since then.
  bit          m_active;
  int          m_start;
  int          m_snap[N];
  int          m_max;
  int          m_ovr;
  logic [N-1:0] m_out;
  bit          m_busy;

  task automatic m_take();
    m_max = 0;
    for (int i = 0; i < N; i++) begin
      m_snap[i] = int'(delays[i*DW +: DW]);
      if (m_snap[i] > m_max) m_max = m_snap[i];
    end
  endtask

  task automatic model_step();
    int e, k;
    bit last;
    e = cyc + 1;
    m_out = '0;
    if (reset) begin
      m_active = 0;
      m_ovr    = 0;
      m_busy   = 0;
    end else begin
      m_busy = m_active;
      if (m_active) begin
        k = e - m_start - 1;
        for (int i = 0; i < N; i++) m_out[i] = (k == m_snap[i]);
        last = (k == m_max);
        if (enable_in && !last) m_ovr++;
        if (!sequence_enable) m_active = 0;
        else if (last) begin
          if (enable_in) begin m_start = e; m_take(); end
          else m_active = 0;
        end
      end else if (enable_in && sequence_enable) begin
        m_active = 1;
        m_start  = e;
        m_take();
      end
      if (clear_overrun) m_ovr = 0;
    end
  endtask

  initial begin
    logic [N-1:0] acc;
    logic         busy_acc;

    vecs[0] = mk(0, 3, 7, 12, 13);
    vecs[1] = mk(2, 2, 2, 2, 3);
    vecs[2] = mk(0, 0, 0, 0, 1);
    vecs[3] = mk(5, 1, 0, 9, 10);
    vecs[4] = mk(20, 0, 20, 3, 21);

    reset = 1'b1; enable_in = 1'b0; sequence_enable = 1'b1;
    clear_overrun = 1'b0; delays = '0;
    tick(); tick();
    chk("reset_enable_out", 32'(enable_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_overrun", 32'(overrun_count), 32'd0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) run_vec(v, "vec");

    // Overrun then back-to-back restart on the terminal cycle.
    delays = {16'd12, 16'd7, 16'd3, 16'd0};
    trigger();
    for (int k = 1; k <= 28; k++) begin
      enable_in = (k == 5) || (k == 13);
      tick();
      enable_in = 1'b0;
      if (k == 5)  chk("ovr_count_after_t5", 32'(overrun_count), 32'd1);
      if (k == 13) chk("ovr_terminal_out", 32'(enable_out), 32'h8);
      if (k == 14) begin
        chk("restart_ch0_out", 32'(enable_out), 32'h1);
        chk("restart_busy", 32'(busy), 32'd1);
      end
      if (k == 26) chk("restart_ch3_out", 32'(enable_out), 32'h8);
      if (k == 27) chk("restart_busy_end", 32'(busy), 32'd0);
    end
    chk("ovr_count_final", 32'(overrun_count), 32'd1);

    // Delay changes after the trigger only affect the following trigger.
    delays = {4{16'd2}};
    trigger();
    delays = {4{16'd9}};
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 2) chk("snap_before", 32'(enable_out), 32'h0);
      if (k == 3) chk("snap_all", 32'(enable_out), 32'hF);
    end
    trigger();
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 9)  chk("snap_new_before", 32'(enable_out), 32'h0);
      if (k == 10) chk("snap_new_all", 32'(enable_out), 32'hF);
    end

    // Abort via sequence_enable, then gated trigger.
    delays = {16'd12, 16'd7, 16'd3, 16'd0};
    trigger();
    acc = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 4) sequence_enable = 1'b0;
      tick();
      acc |= enable_out;
      if (k == 4) chk("abort_busy_t4", 32'(busy), 32'd1);
      if (k == 5) chk("abort_busy_t5", 32'(busy), 32'd0);
    end
    chk("abort_pulses", 32'(acc), 32'h3);
    acc = '0; busy_acc = 1'b0;
    trigger();
    for (int k = 1; k <= 15; k++) begin
      tick();
      acc |= enable_out;
      busy_acc |= busy;
    end
    chk("gated_out", 32'(acc), 32'h0);
    chk("gated_busy", 32'(busy_acc), 32'd0);
    chk("gated_overrun", 32'(overrun_count), 32'd1);
    sequence_enable = 1'b1;

    // Saturation on the 2-bit instance and clear-beats-increment.
    clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
    delays = {4{16'd20}};
    trigger();
    enable_in = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    chk("sat_overrun_2bit", 32'(overrun_s), 32'd3);
    chk("sat_overrun_16bit", 32'(overrun_count), 32'd5);
    clear_overrun = 1'b1;
    tick();
    enable_in = 1'b0; clear_overrun = 1'b0;
    chk("clear_wins_2bit", 32'(overrun_s), 32'd0);
    chk("clear_wins_16bit", 32'(overrun_count), 32'd0);
    for (int k = 7; k <= 23; k++) tick();
    chk("sat_seq_idle", 32'(busy), 32'd0);

    // Reset in the middle of a sequence.
    delays = {16'd12, 16'd7, 16'd3, 16'd0};
    trigger();
    for (int k = 1; k <= 4; k++) tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_mid_out_t6", 32'(enable_out), 32'h0);
    chk("rst_mid_busy_t6", 32'(busy), 32'd0);
    acc = '0; busy_acc = 1'b0;
    for (int k = 7; k <= 20; k++) begin
      tick();
      acc |= enable_out;
      busy_acc |= busy;
    end
    chk("rst_mid_out_after", 32'(acc), 32'h0);
    chk("rst_mid_busy_after", 32'(busy_acc), 32'd0);
    run_vec(0, "post_rst");

    // Randomized run against the reference model.
    for (int it = 0; it < 3000; it++) begin
      reset           = (it == 0) || ($urandom_range(0, 199) == 0);
      enable_in       = ($urandom_range(0, 3) == 0);
      sequence_enable = ($urandom_range(0, 15) != 0);
      clear_overrun   = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < N; i++) delays[i*DW +: DW] = 16'($urandom_range(0, 15));
      model_step();
      tick();
      chk($sformatf("rnd_out_%0d", it), 32'(enable_out), 32'(m_out));
      chk($sformatf("rnd_out_s_%0d", it), 32'(enable_out_s), 32'(m_out));
      chk($sformatf("rnd_busy_%0d", it), 32'(busy), 32'(m_busy));
      chk($sformatf("rnd_ovr16_%0d", it), 32'(overrun_count),
          32'((m_ovr > 65535) ? 65535 : m_ovr));
      chk($sformatf("rnd_ovr2_%0d", it), 32'(overrun_s),
          32'((m_ovr > 3) ? 3 : m_ovr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
